// File: rtl/pipe_pkg.sv
// Shared pipeline types: arbiter state, memory owner and default bus widths.
package pipe_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/pipe_arb_starve.sv
// Grant decision between fetch and data, with a saturating counter that
// forces one fetch grant after STARVE_MAX consecutive fetch losses.
module pipe_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic arb_en,
  output logic grant_if
);

  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic          force_if;

  // With STARVE_MAX = 0 the counter never leaves 0 and data always wins.
  assign force_if = (STARVE_MAX > 0) && (starve_cnt == CNT_MAX);
  assign grant_if = if_req && (!d_req || force_if);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (if_req && d_req && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Single-port memory arbiter for the IF and MEM stages over a req/gnt/rvalid bus.
// Optional stall-cycle counters are enabled by defining PIPE_ARB_PERF_EN.
module pipe_mem_arbiter
  import pipe_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
`ifdef PIPE_ARB_PERF_EN
  output logic [31:0]   perf_if_wait,
  output logic [31:0]   perf_d_wait,
`endif
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata
);

  arb_state_e state;
  owner_e     owner;
  logic       arb_en;
  logic       grant_if;

  assign if_stall = if_req && !if_done;
  assign d_stall  = d_req && !d_done;

  // The done cycle is the bubble: requesters still hold req there, so a
  // request still high afterwards is treated as new and arbitrated next cycle.
  assign arb_en = (state == IDLE) && !if_done && !d_done && (if_req || d_req);

  pipe_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .d_req    (d_req),
    .arb_en   (arb_en),
    .grant_if (grant_if)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en) begin
            state <= REQ;
            m_req <= 1'b1;
            if (grant_if) begin
              owner   <= OWN_IF;
              m_addr  <= if_addr;
              m_we    <= 1'b0;
              m_wdata <= '0;
            end else begin
              owner   <= OWN_D;
              m_addr  <= d_addr;
              m_we    <= d_we;
              m_wdata <= d_wdata;
            end
          end
        end
        REQ: begin
          if (m_gnt) begin
            state <= RESP;
            m_req <= 1'b0;
          end
        end
        RESP: begin
          if (m_rvalid) begin
            state <= IDLE;
            if (owner == OWN_IF) begin
              if_done  <= 1'b1;
              if_rdata <= m_rdata;
            end else begin
              d_done <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_wait <= '0;
      perf_d_wait  <= '0;
    end else begin
      if (if_stall) perf_if_wait <= perf_if_wait + 32'd1;
      if (d_stall)  perf_d_wait  <= perf_d_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: three instances (STARVE_MAX 4, 2, 0),
// each with a simple memory responder whose grant delay is set per test.
`timescale 1ns/1ps
module tb_pipe_mem_arbiter;
  import pipe_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req [N];
  logic          d_req  [N];
  logic [AW-1:0] if_addr, d_addr;
  logic          d_we;
  logic [DW-1:0] d_wdata;
  int            gnt_wait;
  logic          force_rvalid;

  logic [DW-1:0] if_rdata [N];
  logic [DW-1:0] d_rdata  [N];
  logic          if_done  [N];
  logic          d_done   [N];
  logic          if_stall [N];
  logic          d_stall  [N];
  logic          m_req    [N];
  logic          m_we     [N];
  logic          m_gnt    [N];
  logic          m_rvalid [N];
  logic [AW-1:0] m_addr   [N];
  logic [DW-1:0] m_wdata  [N];
  logic [DW-1:0] m_rdata  [N];
`ifdef PIPE_ARB_PERF_EN
  logic [31:0]   perf_if_wait [N];
  logic [31:0]   perf_d_wait  [N];
`endif

  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 32'h40) ? 32'h00A00093 : {a[15:0], ~a[15:0]};
  endfunction

  for (genvar g = 0; g < N; g++) begin : gen_dut
    localparam int SM = (g == 0) ? 4 : (g == 1) ? 2 : 0;
    int            wcnt;
    logic          pend;
    logic [AW-1:0] raddr;

    pipe_mem_arbiter #(
      .AW(AW), .DW(DW), .STARVE_MAX(SM)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr),
      .if_rdata (if_rdata[g]),
      .if_done  (if_done[g]),
      .if_stall (if_stall[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata[g]),
      .d_done   (d_done[g]),
      .d_stall  (d_stall[g]),
`ifdef PIPE_ARB_PERF_EN
      .perf_if_wait (perf_if_wait[g]),
      .perf_d_wait  (perf_d_wait[g]),
`endif
      .m_req    (m_req[g]),
      .m_we     (m_we[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_gnt    (m_gnt[g]),
      .m_rvalid (m_rvalid[g]),
      .m_rdata  (m_rdata[g])
    );

    assign m_gnt[g]    = m_req[g] && (wcnt == gnt_wait);
    assign m_rvalid[g] = pend || force_rvalid;
    assign m_rdata[g]  = pend ? mem_word(raddr) : 32'hBAD0BAD0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wcnt  <= 0;
        pend  <= 1'b0;
        raddr <= '0;
      end else begin
        pend <= m_req[g] && m_gnt[g];
        if (m_req[g] && m_gnt[g]) begin
          wcnt  <= 0;
          raddr <= m_addr[g];
        end else if (m_req[g]) begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  typedef struct {
    logic          is_if;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gw;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction on instance 0, sampled once per cycle just after the negedge.
  task automatic run_vec(input vec_t v, input string tag);
    int            cyc, first_req, done_cyc, req_cycles, stall_bad;
    logic [AW-1:0] acc_addr;
    logic          acc_we;
    logic [DW-1:0] acc_wdata;
    logic          dn, st;
    @(negedge clk);
    gnt_wait = v.gw;
    if_addr  = v.addr;
    d_addr   = v.addr;
    d_we     = v.we;
    d_wdata  = v.wdata;
    if (v.is_if) if_req[0] = 1'b1;
    else d_req[0] = 1'b1;
    cyc = 0; first_req = -1; done_cyc = -1; req_cycles = 0; stall_bad = 0;
    acc_addr = '0; acc_we = 1'b0; acc_wdata = '0;
    while (done_cyc < 0 && cyc < 40) begin
      #1;
      dn = v.is_if ? if_done[0] : d_done[0];
      st = v.is_if ? if_stall[0] : d_stall[0];
      if (m_req[0]) begin
        req_cycles++;
        if (first_req < 0) first_req = cyc;
      end
      if (m_req[0] && m_gnt[0]) begin
        acc_addr  = m_addr[0];
        acc_we    = m_we[0];
        acc_wdata = m_wdata[0];
      end
      if (st != (cyc < v.exp_lat)) stall_bad++;
      if (dn) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
    check({tag, "_first_req"}, 64'(first_req), 64'd1);
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_lat));
    check({tag, "_req_held"}, 64'(req_cycles), 64'(v.gw + 1));
    check({tag, "_stall_shape"}, 64'(stall_bad), 64'd0);
    check({tag, "_acc_addr"}, 64'(acc_addr), 64'(v.addr));
    check({tag, "_acc_we"}, 64'(acc_we), 64'(v.we));
    if (v.we) check({tag, "_acc_wdata"}, 64'(acc_wdata), 64'(v.wdata));
    check({tag, "_rdata"}, 64'(v.is_if ? if_rdata[0] : d_rdata[0]), 64'(v.exp_rdata));
  endtask

  // Holds both requests on instance k and records which side wins each accept.
  task automatic run_starve(input int k, input int n, input logic [7:0] exp_bits, input string tag);
    logic [7:0] bits;
    int         acc, dones;
    bits = '0; acc = 0; dones = 0;
    @(negedge clk);
    gnt_wait = 0;
    if_addr  = 32'h80;
    d_addr   = 32'h300;
    d_we     = 1'b0;
    if_req[k] = 1'b1;
    d_req[k]  = 1'b1;
    for (int c = 0; c < 200 && dones < n; c++) begin
      #1;
      if (m_req[k] && m_gnt[k]) begin
        if (acc < 8) bits[acc] = (m_addr[k] == 32'h80);
        acc++;
      end
      if (if_done[k] || d_done[k]) dones++;
      @(negedge clk);
    end
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
    check({tag, "_grant_order"}, 64'(bits), 64'(exp_bits));
    check({tag, "_accepts"}, 64'(acc), 64'(n));
  endtask

  initial begin
    int  got, saw_if, pulses;

    vecs[0] = '{1'b1, 1'b0, 32'h40,   32'h0,        0, 32'h00A00093, 3};
    vecs[1] = '{1'b0, 1'b0, 32'h100,  32'h0,        1, 32'h0100FEFF, 4};
    vecs[2] = '{1'b0, 1'b1, 32'h200,  32'hDEADBEEF, 3, 32'h0100FEFF, 6};
    vecs[3] = '{1'b1, 1'b0, 32'h1234, 32'h0,        2, 32'h1234EDCB, 5};
    vecs[4] = '{1'b0, 1'b0, 32'h0,    32'h0,        0, 32'h0000FFFF, 3};

    for (int i = 0; i < N; i++) begin
      if_req[i] = 1'b0;
      d_req[i]  = 1'b0;
    end
    if_addr = '0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
    gnt_wait = 0; force_rvalid = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_m_req", 64'(m_req[0]), 64'd0);
    check("reset_m_addr", 64'(m_addr[0]), 64'd0);
    check("reset_if_done", 64'(if_done[0]), 64'd0);
    check("reset_d_rdata", 64'(d_rdata[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Simultaneous requests, STARVE_MAX = 4: data first, then fetch.
    @(negedge clk);
    gnt_wait = 0; if_addr = 32'h44; d_addr = 32'h180; d_we = 1'b0;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    got = 0; saw_if = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      #1;
      if (if_done[0]) saw_if = 1;
      if (d_done[0]) got = 1;
      @(negedge clk);
    end
    d_req[0] = 1'b0;
    check("both_d_done", 64'(got), 64'd1);
    check("both_if_not_first", 64'(saw_if), 64'd0);
    check("both_d_rdata", 64'(d_rdata[0]), 64'h0180FE7F);
    check("both_starve_after_d", 64'(gen_dut[0].u_dut.u_starve.starve_cnt), 64'd1);
    got = 0;
    for (int c = 0; c < 40 && got == 0; c++) begin
      #1;
      if (if_done[0]) got = 1;
      @(negedge clk);
    end
    if_req[0] = 1'b0;
    check("both_if_done", 64'(got), 64'd1);
    check("both_if_rdata", 64'(if_rdata[0]), 64'h0044FFBB);
    check("both_starve_cleared", 64'(gen_dut[0].u_dut.u_starve.starve_cnt), 64'd0);

    run_starve(0, 6, 8'b0001_0000, "starve4");
    run_starve(1, 4, 8'b0000_0100, "starve2");
    run_starve(2, 6, 8'b0000_0000, "starve0");

    // Reset while the load sits in RESP; a late rvalid must not produce done.
    @(negedge clk);
    gnt_wait = 0; d_addr = 32'h100; d_we = 1'b0; d_req[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_resp", 64'(gen_dut[0].u_dut.state), 64'(RESP));
    rst_n = 1'b0;
    d_req[0] = 1'b0;
    #1;
    check("rst_m_req", 64'(m_req[0]), 64'd0);
    check("rst_m_addr", 64'(m_addr[0]), 64'd0);
    check("rst_d_rdata", 64'(d_rdata[0]), 64'd0);
    check("rst_if_rdata", 64'(if_rdata[0]), 64'd0);
    check("rst_d_done", 64'(d_done[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    force_rvalid = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (if_done[0] || d_done[0] || m_req[0]) pulses++;
      @(negedge clk);
      if (c == 1) force_rvalid = 1'b0;
    end
    check("late_rvalid_no_done", 64'(pulses), 64'd0);

`ifdef PIPE_ARB_PERF_EN
    begin
      vec_t pf;
      pf = '{1'b1, 1'b0, 32'h40, 32'h0, 2, 32'h00A00093, 5};
      run_vec(pf, "perf_if");
      check("perf_d_idle", 64'(perf_d_wait[0]), 64'd0);
      pf = '{1'b0, 1'b0, 32'h100, 32'h0, 0, 32'h0100FEFF, 3};
      run_vec(pf, "perf_d");
      @(negedge clk);
      check("perf_if_wait", 64'(perf_if_wait[0]), 64'd5);
      check("perf_d_wait", 64'(perf_d_wait[0]), 64'd3);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
